// File: rtl/glycemic_calc_scheduler.sv
// Round-robin scheduler that time-shares one combinational glycemic-index
// calculator between N_CH patient sensor channels. A granted channel's sample
// is registered onto the calculator input and held for SETTLE cycles. The
// index is then captured and offered on a valid/ready response port, together
// with the channel number and an alarm flag.
module glycemic_calc_scheduler #(
  parameter int         N_CH     = 4,
  parameter int         SETTLE   = 2,
  parameter logic [3:0] ALARM_TH = 4'd12,
  localparam int        CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     req,
  input  logic [8*N_CH-1:0]   sensorData,
  output logic [N_CH-1:0]     grant,
  output logic [7:0]          calcBloodSensor,
  input  logic [3:0]          calcGlycemicIndex,
  output logic                respValid,
  input  logic                respReady,
  output logic [CH_W-1:0]     respCh,
  output logic [3:0]          respIndex,
  output logic                respAlarm,
  output logic                busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_last;
  logic [N_CH-1:0]   r_grant;
  logic [7:0]        r_sample;
  logic              r_valid;
  logic [CH_W-1:0]   r_ch;
  logic [3:0]        r_index;
  logic              r_alarm;
  logic              r_busy;

  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_sel;
  logic              w_any;
  logic [7:0]        w_data;

  // Pick the first requester above the last served channel, wrapping around;
  // scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    w_idx = '0;
    w_sel = '0;
    w_any = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      w_idx = CH_W'((int'(r_last) + k) % N_CH);
      if (req[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end else begin
        w_sel = w_sel;
      end
    end
  end

  // Route the selected channel's sample byte toward the calculator register.
  always_comb begin
    w_data = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      if (w_sel == CH_W'(i)) begin
        w_data = sensorData[i*8 +: 8];
      end else begin
        w_data = w_data;
      end
    end
  end

  // Scheduler FSM: arbitrate in IDLE, hold the calculator input while it
  // settles, then keep the captured response until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_last   <= CH_W'(N_CH - 1);
      r_grant  <= '0;
      r_sample <= 8'h00;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_index  <= 4'd0;
      r_alarm  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant  <= {{(N_CH-1){1'b0}}, 1'b1} << w_sel;
            r_sample <= w_data;
            r_ch     <= w_sel;
            r_last   <= w_sel;
            r_cnt    <= CNT_W'(SETTLE - 1);
            r_busy   <= 1'b1;
            r_state  <= ST_SETTLE;
          end else begin
            r_grant  <= '0;
            r_state  <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          r_grant <= '0;
          if (r_cnt == '0) begin
            r_index <= calcGlycemicIndex;
            r_alarm <= (calcGlycemicIndex >= ALARM_TH);
            r_valid <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_grant <= '0;
          if (respReady) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_grant <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant           = r_grant;
  assign calcBloodSensor = r_sample;
  assign respValid       = r_valid;
  assign respCh          = r_ch;
  assign respIndex       = r_index;
  assign respAlarm       = r_alarm;
  assign busy            = r_busy;

endmodule

// File: tb/tb_glycemic_calc_scheduler.sv
// Self-checking bench for glycemic_calc_scheduler. A transaction-level
// reference model predicts every output on every cycle. Directed scenarios
// check ordering, timing and reset behaviour, and a random phase stresses
// arbitration and backpressure.
module tb_glycemic_calc_scheduler;

  localparam int         N_CH     = 4;
  localparam int         SETTLE   = 2;
  localparam logic [3:0] ALARM_TH = 4'd12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [31:0] sensor_data = 32'd0;
  logic [3:0]  grant;
  logic [7:0]  calc_bs;
  logic [3:0]  calc_gi;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_ch;
  logic [3:0]  resp_index;
  logic        resp_alarm;
  logic        busy;

  glycemic_calc_scheduler #(.N_CH(N_CH), .SETTLE(SETTLE), .ALARM_TH(ALARM_TH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sensorData(sensor_data),
    .grant(grant), .calcBloodSensor(calc_bs), .calcGlycemicIndex(calc_gi),
    .respValid(resp_valid), .respReady(resp_ready), .respCh(resp_ch),
    .respIndex(resp_index), .respAlarm(resp_alarm), .busy(busy)
  );

  // Calculator stub: the index is the sample's upper nibble.
  assign calc_gi = calc_bs[7:4];

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  bit mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Round-robin choice from the service rules: first requester after 'last'.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    int c;
    rr_pick = -1;
    for (int k = 1; k <= N_CH; k++) begin
      c = (last + k) % N_CH;
      if (rr_pick < 0 && r[c[1:0]]) rr_pick = c;
    end
  endfunction

  function automatic int oh2idx(input logic [3:0] g);
    oh2idx = -1;
    for (int i = 0; i < N_CH; i++) if (g[i]) oh2idx = i;
  endfunction

  // ---------------- reference model ----------------
  logic [3:0] exp_grant;
  logic [7:0] exp_sample;
  logic       exp_valid;
  logic [1:0] exp_ch;
  logic [3:0] exp_index;
  logic       exp_alarm;
  logic       exp_busy;
  logic       m_active;
  int         m_age;
  int         m_last;
  int         pick_now;

  always_comb pick_now = rr_pick(req, m_last);

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // A service is an episode: it starts at a grant, produces its response
  // SETTLE cycles later and ends at the handshake after that.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_grant <= 4'd0; exp_sample <= 8'd0; exp_valid <= 1'b0; exp_ch <= 2'd0;
      exp_index <= 4'd0; exp_alarm <= 1'b0; exp_busy <= 1'b0;
      m_active <= 1'b0; m_age <= 0; m_last <= N_CH - 1;
    end else begin
      exp_grant <= 4'd0;
      if (!m_active) begin
        if (pick_now >= 0) begin
          exp_grant  <= 4'(1 << pick_now);
          exp_sample <= 8'(sensor_data >> (8 * pick_now));
          exp_ch     <= 2'(pick_now);
          m_last     <= pick_now;
          m_active   <= 1'b1;
          m_age      <= 0;
          exp_busy   <= 1'b1;
        end
      end else begin
        m_age <= m_age + 1;
        if (!exp_valid) begin
          if (m_age + 1 == SETTLE) begin
            exp_valid <= 1'b1;
            exp_index <= exp_sample[7:4];
            exp_alarm <= (exp_sample[7:4] >= ALARM_TH);
          end
        end else if (resp_ready) begin
          exp_valid <= 1'b0;
          exp_busy  <= 1'b0;
          m_active  <= 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("grant", grant, exp_grant);
      check_eq("calc_sample", calc_bs, exp_sample);
      check_eq("resp_valid", resp_valid, exp_valid);
      check_eq("resp_ch", resp_ch, exp_ch);
      check_eq("resp_index", resp_index, exp_index);
      check_eq("resp_alarm", resp_alarm, exp_alarm);
      check_eq("busy", busy, exp_busy);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_grant(output int ch, output int t);
    ch = -1;
    t  = 0;
    for (int i = 0; i < 40 && ch < 0; i++) begin
      @(negedge clk);
      if (grant != 4'd0) begin
        ch = oh2idx(grant);
        t  = cyc_n;
      end
    end
    if (ch < 0) check_eq("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int ch, t, t_prev;
  int rr_order[5] = '{0, 1, 2, 3, 0};
  int rr_index[5] = '{1, 9, 1, 15, 1};

  initial begin
    do_reset();
    mon_en = 1'b1;
    check_eq("rst_grant", grant, 32'd0);
    check_eq("rst_sample", calc_bs, 32'd0);
    check_eq("rst_valid", resp_valid, 32'd0);
    check_eq("rst_busy", busy, 32'd0);

    // Single request on channel 0.
    resp_ready = 1'b1;
    sensor_data[7:0] = 8'h11;
    req = 4'b0001;
    wait_grant(ch, t);
    check_eq("single_ch", ch, 32'd0);
    check_eq("single_sample", calc_bs, 32'h11);
    req = 4'b0000;
    @(negedge clk);
    check_eq("single_grant_width", grant, 32'd0);
    check_eq("single_early_valid", resp_valid, 32'd0);
    @(negedge clk);
    check_eq("single_valid", resp_valid, 32'd1);
    check_eq("single_rch", resp_ch, 32'd0);
    check_eq("single_idx", resp_index, 32'd1);
    check_eq("single_alarm", resp_alarm, 32'd0);
    @(negedge clk);
    check_eq("single_valid_drop", resp_valid, 32'd0);
    check_eq("single_busy_drop", busy, 32'd0);

    // Alarm with backpressure on channel 2.
    resp_ready = 1'b0;
    sensor_data[23:16] = 8'hD1;
    req = 4'b0100;
    wait_grant(ch, t);
    check_eq("bp_ch", ch, 32'd2);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", resp_valid, 32'd1);
      check_eq("bp_idx", resp_index, 32'd13);
      check_eq("bp_alarm", resp_alarm, 32'd1);
      check_eq("bp_rch", resp_ch, 32'd2);
      check_eq("bp_busy", busy, 32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_valid_drop", resp_valid, 32'd0);
    check_eq("bp_busy_drop", busy, 32'd0);

    // Round robin with all channels requesting.
    do_reset();
    resp_ready  = 1'b1;
    sensor_data = 32'hF017_9111;
    req = 4'b1111;
    t_prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(ch, t);
      check_eq("rr_order", ch, rr_order[g]);
      if (g > 0) check_eq("rr_spacing", t - t_prev, SETTLE + 2);
      t_prev = t;
      req[2'(ch)] = 1'b0;
      @(negedge clk);
      req[2'(ch)] = 1'b1;
      @(negedge clk);
      check_eq("rr_valid", resp_valid, 32'd1);
      check_eq("rr_idx", resp_index, rr_index[g]);
    end
    req = 4'b0000;
    wait_idle();

    // Priority after serving channel 1.
    req = 4'b0010;
    wait_grant(ch, t);
    check_eq("prio_first", ch, 32'd1);
    req = 4'b0000;
    wait_idle();
    req = 4'b0011;
    wait_grant(ch, t);
    check_eq("prio_ch0", ch, 32'd0);
    req[0] = 1'b0;
    wait_grant(ch, t);
    check_eq("prio_ch1", ch, 32'd1);
    req = 4'b0000;
    wait_idle();

    // Asynchronous reset during settle.
    sensor_data[31:24] = 8'hE5;
    req = 4'b1000;
    wait_grant(ch, t);
    check_eq("mid_ch", ch, 32'd3);
    req = 4'b0000;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_grant", grant, 32'd0);
    check_eq("arst_sample", calc_bs, 32'd0);
    check_eq("arst_valid", resp_valid, 32'd0);
    check_eq("arst_rch", resp_ch, 32'd0);
    check_eq("arst_idx", resp_index, 32'd0);
    check_eq("arst_alarm", resp_alarm, 32'd0);
    check_eq("arst_busy", busy, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("arst_no_resp", resp_valid, 32'd0);
    req = 4'b1010;
    wait_grant(ch, t);
    check_eq("arst_first", ch, 32'd1);
    req = 4'b0000;
    wait_idle();

    // Late request raised while a response is pending.
    resp_ready = 1'b0;
    req = 4'b0001;
    wait_grant(ch, t);
    check_eq("late_ch0", ch, 32'd0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    check_eq("late_valid", resp_valid, 32'd1);
    req[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("late_no_grant", grant, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("late_hs_valid", resp_valid, 32'd0);
    check_eq("late_hs_grant", grant, 32'd0);
    @(negedge clk);
    check_eq("late_grant3", grant, 32'b1000);
    req = 4'b0000;
    wait_idle();

    // Random traffic and backpressure, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      resp_ready = ($urandom_range(2) != 0);
      for (int c = 0; c < N_CH; c++) begin
        if (req[c]) begin
          if (exp_grant[c] && ($urandom_range(1) == 0)) req[c] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          sensor_data[8*c +: 8] = 8'($urandom);
          req[c] = 1'b1;
        end
      end
    end
    req = 4'b0000;
    resp_ready = 1'b1;
    wait_idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
